ysyx_25040111_lsu_axi: RTL

YSYX_25040111_LSU_AXI -- requirements
Module: ysyx_25040111_lsu_axi

---
 rtl/ysyx_25040111_lsu_axi.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040111_lsu_axi.sv
// Load/store unit bridge to an AXI4 master port: one read FSM (single or burst
// reads with alignment/extension) and one write FSM (single-beat writes).
module ysyx_25040111_lsu_axi #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MAX_LEN = 8,
    parameter int AXI_ID  = 0
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  lsu_rvalid,
    input  logic [ADDR_W-1:0]     lsu_raddr,
    input  logic [1:0]            lsu_rsize,
    input  logic                  lsu_rsign,
    input  logic [7:0]            lsu_rlen,
    output logic                  lsu_rready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic                  lsu_rlast,
    output logic                  lsu_rerr,

    input  logic                  lsu_wvalid,
    input  logic [ADDR_W-1:0]     lsu_waddr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [1:0]            lsu_wsize,
    output logic                  lsu_wready,
    output logic                  lsu_werr,

    output logic                  io_master_awvalid,
    input  logic                  io_master_awready,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic [3:0]            io_master_awid,
    output logic [7:0]            io_master_awlen,
    output logic [2:0]            io_master_awsize,
    output logic [1:0]            io_master_awburst,
    output logic                  io_master_wvalid,
    input  logic                  io_master_wready,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    output logic                  io_master_wlast,
    input  logic                  io_master_bvalid,
    output logic                  io_master_bready,
    input  logic [1:0]            io_master_bresp,
    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    output logic [ADDR_W-1:0]     io_master_araddr,
    output logic [3:0]            io_master_arid,
    output logic [7:0]            io_master_arlen,
    output logic [2:0]            io_master_arsize,
    output logic [1:0]            io_master_arburst,
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic [1:0]            io_master_rresp,
    input  logic                  io_master_rlast
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

    r_state_e              r_state_q, r_state_d;
    logic [ADDR_W-1:0]     r_addr_q, r_addr_d;
    logic [1:0]            r_size_q, r_size_d;
    logic                  r_sign_q, r_sign_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic                  r_err_q, r_err_d;
    logic                  r_fault_q, r_fault_d;

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_W-1:0]     w_addr_q, w_addr_d;
    logic [DATA_W-1:0]     w_data_q, w_data_d;
    logic [1:0]            w_size_q, w_size_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  w_fault_q, w_fault_d;

    logic r_idle, w_idle, r_accept, w_accept, r_bad, w_bad;
    logic r_beat, r_final, beat_err;
    logic aw_hs, w_hs;
    logic unused_bits;

    function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return lo[0];
            2'd2:    return |lo[1:0];
            default: return |lo;
        endcase
    endfunction

    // A pending fault pulse keeps the FSM non-idle so the still-held request is not re-accepted.
    assign r_idle   = (r_state_q == R_IDLE) && !r_fault_q;
    assign w_idle   = (w_state_q == W_IDLE) && !w_fault_q;
    assign w_accept = lsu_wvalid && r_idle && w_idle;
    assign r_accept = lsu_rvalid && !lsu_wvalid && r_idle && w_idle;

    assign r_bad = misaligned(lsu_raddr[2:0], lsu_rsize)
                || ((lsu_rsize == 2'd3) && (DATA_W == 32))
                || (32'(lsu_rlen) > 32'(MAX_LEN - 1))
                || ((lsu_rlen != 8'd0) && (lsu_rsize < 2'(OFF_W)));
    assign w_bad = misaligned(lsu_waddr[2:0], lsu_wsize)
                || ((lsu_wsize == 2'd3) && (DATA_W == 32));

    assign r_beat   = (r_state_q == R_DATA) && io_master_rvalid;
    assign r_final  = (r_cnt_q == r_len_q);
    assign beat_err = io_master_rresp[1] || (io_master_rlast != r_final);

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_size_d  = r_size_q;
        r_sign_d  = r_sign_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        r_fault_d = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (r_accept) begin
                    r_addr_d = lsu_raddr;
                    r_size_d = lsu_rsize;
                    r_sign_d = lsu_rsign;
                    r_len_d  = lsu_rlen;
                    r_cnt_d  = 8'd0;
                    r_err_d  = 1'b0;
                    if (r_bad) r_fault_d = 1'b1;
                    else       r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (io_master_arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_beat) begin
                    r_cnt_d = r_cnt_q + 8'd1;
                    r_err_d = r_err_q | beat_err;
                    if (r_final) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_size_q  <= 2'd0;
            r_sign_q  <= 1'b0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_err_q   <= 1'b0;
            r_fault_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_size_q  <= r_size_d;
            r_sign_q  <= r_sign_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            r_fault_q <= r_fault_d;
        end
    end

    // Only single-beat reads are lane-shifted; legal bursts are always full width.
    logic [DATA_W-1:0] r_shifted, r_mask;
    logic              r_sbit;
    always_comb begin
        r_shifted = (r_len_q == 8'd0) ? (io_master_rdata >> {r_addr_q[OFF_W-1:0], 3'b000})
                                      : io_master_rdata;
        r_mask = '1;
        r_sbit = r_shifted[DATA_W-1];
        case (r_size_q)
            2'd0: begin r_mask = DATA_W'(8'hFF);         r_sbit = r_shifted[7];  end
            2'd1: begin r_mask = DATA_W'(16'hFFFF);      r_sbit = r_shifted[15]; end
            2'd2: begin r_mask = DATA_W'(32'hFFFF_FFFF); r_sbit = r_shifted[31]; end
            default: ;
        endcase
        lsu_rdata = (r_sign_q && r_sbit) ? (r_shifted | ~r_mask) : (r_shifted & r_mask);
    end

    assign lsu_rready = r_beat || r_fault_q;
    assign lsu_rlast  = (r_beat && r_final) || r_fault_q;
    assign lsu_rerr   = (r_beat && r_final && (r_err_q || beat_err)) || r_fault_q;

    assign io_master_arvalid = (r_state_q == R_ADDR);
    assign io_master_araddr  = r_addr_q;
    assign io_master_arid    = 4'(AXI_ID);
    assign io_master_arlen   = r_len_q;
    assign io_master_arsize  = {1'b0, r_size_q};
    assign io_master_arburst = (r_len_q != 8'd0) ? 2'b01 : 2'b00;
    assign io_master_rready  = (r_state_q == R_DATA);

    assign aw_hs = io_master_awvalid && io_master_awready;
    assign w_hs  = io_master_wvalid && io_master_wready;

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        w_size_d  = w_size_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        w_fault_d = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (w_accept) begin
                    w_addr_d  = lsu_waddr;
                    w_data_d  = lsu_wdata;
                    w_size_d  = lsu_wsize;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (w_bad) w_fault_d = 1'b1;
                    else       w_state_d = W_SEND;
                end
            end
            W_SEND: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                if (io_master_bvalid) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            w_size_q  <= 2'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            w_fault_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            w_size_q  <= w_size_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            w_fault_q <= w_fault_d;
        end
    end

    logic [STRB_W-1:0] strb_base;
    always_comb begin
        case (w_size_q)
            2'd0:    strb_base = STRB_W'(8'h01);
            2'd1:    strb_base = STRB_W'(8'h03);
            2'd2:    strb_base = STRB_W'(8'h0F);
            default: strb_base = STRB_W'(8'hFF);
        endcase
    end

    assign io_master_awvalid = (w_state_q == W_SEND) && !aw_done_q;
    assign io_master_awaddr  = w_addr_q;
    assign io_master_awid    = 4'(AXI_ID);
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = {1'b0, w_size_q};
    assign io_master_awburst = 2'b01;
    assign io_master_wvalid  = (w_state_q == W_SEND) && !w_done_q;
    assign io_master_wdata   = w_data_q << {w_addr_q[OFF_W-1:0], 3'b000};
    assign io_master_wstrb   = strb_base << w_addr_q[OFF_W-1:0];
    assign io_master_wlast   = io_master_wvalid;
    assign io_master_bready  = (w_state_q == W_RESP);

    assign lsu_wready = ((w_state_q == W_RESP) && io_master_bvalid) || w_fault_q;
    assign lsu_werr   = ((w_state_q == W_RESP) && io_master_bvalid && io_master_bresp[1]) || w_fault_q;

    assign unused_bits = ^{io_master_bresp[0], io_master_rresp[0]};

endmodule
